// File: rtl/mem_addr_gen_scroll.sv
// rtl/mem_addr_gen_scroll.sv - VGA pixel address generator with frames, mirroring and wrap scroll
// Two-stage registered pipeline: stage 1 resolves image coordinates, stage 2 forms the ROM address.
module mem_addr_gen_scroll #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_W     = 3,
  parameter int SCROLL_STEP = 1,
  parameter int ADDR_W      = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  input  logic [FRAME_W-1:0] frame_sel,
  input  logic               mirror_x,
  input  logic               scroll_en,
  input  logic               scroll_dir,
  output logic [ADDR_W-1:0]  pixel_addr,
  output logic               pixel_valid,
  output logic               frame_tick
);

  localparam int OFF_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic               boundary_q, boundary_d;
  logic               tick_q, tick_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               mirror_q, mirror_d;
  logic [OFF_W-1:0]   off_q, off_d;

  logic               img_q, img_d;
  logic [OFF_W-1:0]   sx1_q, sx1_d;
  logic [9:0]         ly1_q, ly1_d;
  logic [FRAME_W-1:0] frame1_q, frame1_d;

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;

  logic        boundary, evt, in_vis, in_img;
  logic [31:0] off_n, lx, ly, mx, sx, addr;

  always_comb begin
    // Counters may sit on the boundary for several cycles; only the first cycle counts.
    boundary   = (h_cnt == 10'd0) && (32'(v_cnt) == SCREEN_H);
    evt        = boundary && !boundary_q;
    boundary_d = boundary;
    tick_d     = evt;
    frame_d    = frame_q;
    mirror_d   = mirror_q;
    off_d      = off_q;

    if (!scroll_dir) begin
      off_n = 32'(off_q) + SCROLL_STEP;
      if (off_n >= IMG_W) off_n = off_n - IMG_W;
    end else if (32'(off_q) < SCROLL_STEP) begin
      off_n = 32'(off_q) + IMG_W - SCROLL_STEP;
    end else begin
      off_n = 32'(off_q) - SCROLL_STEP;
    end

    if (evt) begin
      frame_d  = (32'(frame_sel) >= NUM_FRAMES) ? FRAME_W'(NUM_FRAMES - 1) : frame_sel;
      mirror_d = mirror_x;
      if (scroll_en) off_d = OFF_W'(off_n);
    end

    lx     = 32'(h_cnt) >> SCALE_SHIFT;
    ly     = 32'(v_cnt) >> SCALE_SHIFT;
    in_vis = (32'(h_cnt) < SCREEN_W) && (32'(v_cnt) < SCREEN_H);
    in_img = in_vis && (lx < IMG_W) && (ly < IMG_H);
    mx     = mirror_q ? (IMG_W - 1 - lx) : lx;
    sx     = mx + 32'(off_q);
    if (sx >= IMG_W) sx = sx - IMG_W;

    img_d    = in_img;
    sx1_d    = in_img ? OFF_W'(sx) : '0;
    ly1_d    = in_img ? 10'(ly) : '0;
    frame1_d = frame_q;

    // Frame travels with the pixel so a frame event never retargets an in-flight address.
    addr    = 32'(frame1_q) * (IMG_W * IMG_H) + 32'(ly1_q) * IMG_W + 32'(sx1_q);
    addr_d  = img_q ? ADDR_W'(addr) : '0;
    valid_d = img_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      boundary_q <= 1'b0;
      tick_q     <= 1'b0;
      frame_q    <= '0;
      mirror_q   <= 1'b0;
      off_q      <= '0;
      img_q      <= 1'b0;
      sx1_q      <= '0;
      ly1_q      <= '0;
      frame1_q   <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      boundary_q <= boundary_d;
      tick_q     <= tick_d;
      frame_q    <= frame_d;
      mirror_q   <= mirror_d;
      off_q      <= off_d;
      img_q      <= img_d;
      sx1_q      <= sx1_d;
      ly1_q      <= ly1_d;
      frame1_q   <= frame1_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
    end
  end

  assign pixel_addr  = addr_q;
  assign pixel_valid = valid_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_mem_addr_gen_scroll.sv
// tb/tb_mem_addr_gen_scroll.sv - scoreboard bench for mem_addr_gen_scroll
// Expected outputs are queued at the sampling edge and compared once they reach the outputs.
module tb_mem_addr_gen_scroll;

  typedef struct {
    logic [16:0] addr;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic [2:0]  frame_sel = '0;
  logic        mirror_x = 1'b0;
  logic        scroll_en = 1'b0;
  logic        scroll_dir = 1'b0;
  logic [16:0] pixel_addr;
  logic        pixel_valid;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;

  exp_t sb[$];
  int   m_frame = 0;
  int   m_mirror = 0;
  int   m_off = 0;
  bit   m_bq = 1'b0;

  mem_addr_gen_scroll dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .frame_sel(frame_sel), .mirror_x(mirror_x), .scroll_en(scroll_en),
    .scroll_dir(scroll_dir), .pixel_addr(pixel_addr), .pixel_valid(pixel_valid),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // One clock: model the stage-1 sample, advance the frame-event model, then step past the edge.
  task automatic tick();
    exp_t e;
    bit   bnd, ev;
    int   lx, ly, mx, sx;
    bnd = (h_cnt == 0) && (v_cnt == 480);
    ev  = bnd && !m_bq;
    if (!rst) begin
      m_frame = 0; m_mirror = 0; m_off = 0; m_bq = 1'b0;
      sb.delete();
      e.addr = '0; e.valid = 1'b0;
      sb.push_back(e);
    end else begin
      lx = int'(h_cnt) / 4;
      ly = int'(v_cnt) / 4;
      e.valid = (h_cnt < 640) && (v_cnt < 480) && (lx < 160) && (ly < 120);
      mx = (m_mirror != 0) ? 159 - lx : lx;
      sx = (mx + m_off) % 160;
      e.addr = e.valid ? 17'(m_frame * 19200 + ly * 160 + sx) : 17'd0;
      sb.push_back(e);
      m_bq = bnd;
      if (ev) begin
        m_frame  = (frame_sel >= 3'd4) ? 3 : int'(frame_sel);
        m_mirror = int'(mirror_x);
        if (scroll_en) m_off = scroll_dir ? (m_off + 159) % 160 : (m_off + 1) % 160;
      end
    end
    @(posedge clk);
    #1;
    if (sb.size() > 2) void'(sb.pop_front());
  endtask

  // Holds the counters on the frame boundary for 4 clocks and returns the tick pulses seen.
  task automatic frame_event(output int ticks);
    ticks = 0;
    h_cnt = 10'd0; v_cnt = 10'd480;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (frame_tick) ticks++;
    end
    v_cnt = 10'd0;
    tick();
    if (frame_tick) ticks++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd0 || pixel_valid !== 1'b0 || frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: addr=%0d valid=%0b tick=%0b expected 0/0/0", pixel_addr, pixel_valid, frame_tick);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    h_cnt = 10'd8; v_cnt = 10'd4;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd162 || pixel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_162: addr=%0d valid=%0b expected 162/1", pixel_addr, pixel_valid);
    end
    h_cnt = 10'd639; v_cnt = 10'd479;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd19199 || pixel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_corner: addr=%0d valid=%0b expected 19199/1", pixel_addr, pixel_valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      if (i < 20) begin
        h_cnt = 10'(620 + i); v_cnt = 10'd100;
      end else begin
        h_cnt = 10'($urandom_range(799, 0)); v_cnt = 10'($urandom_range(479, 0));
      end
      tick();
      if (sb.size() == 2) begin
        e = sb.pop_front();
        vectors++;
        if (pixel_addr !== e.addr || pixel_valid !== e.valid) begin
          miscompares++;
          $display("FAIL stream[%0d]: addr=%0d valid=%0b expected %0d/%0b", i, pixel_addr, pixel_valid, e.addr, e.valid);
        end
      end
    end
  endtask

  task automatic test_frame_sel();
    int t;
    frame_sel = 3'd2;
    h_cnt = 10'd0; v_cnt = 10'd0;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd0 || pixel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_no_tear: addr=%0d valid=%0b expected 0/1", pixel_addr, pixel_valid);
    end
    frame_event(t);
    h_cnt = 10'd0; v_cnt = 10'd0;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd38400 || pixel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_sel2: addr=%0d valid=%0b expected 38400/1", pixel_addr, pixel_valid);
    end
  endtask

  task automatic test_mirror();
    int t;
    frame_sel = 3'd0; mirror_x = 1'b1;
    frame_event(t);
    mirror_x = 1'b0;
    h_cnt = 10'd0; v_cnt = 10'd0;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd159 || pixel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mirror_left: addr=%0d valid=%0b expected 159/1", pixel_addr, pixel_valid);
    end
    h_cnt = 10'd636;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd0 || pixel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mirror_right: addr=%0d valid=%0b expected 0/1", pixel_addr, pixel_valid);
    end
    frame_event(t);
  endtask

  task automatic test_invisible_clamp();
    int t;
    h_cnt = 10'd700; v_cnt = 10'd0;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd0 || pixel_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL invis_h: addr=%0d valid=%0b expected 0/0", pixel_addr, pixel_valid);
    end
    h_cnt = 10'd0; v_cnt = 10'd490;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd0 || pixel_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL invis_v: addr=%0d valid=%0b expected 0/0", pixel_addr, pixel_valid);
    end
    frame_sel = 3'd5;
    frame_event(t);
    h_cnt = 10'd0; v_cnt = 10'd0;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd57600 || pixel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL clamp: addr=%0d valid=%0b expected 57600/1", pixel_addr, pixel_valid);
    end
    frame_sel = 3'd0;
    frame_event(t);
  endtask

  task automatic test_scroll();
    int t, total;
    total = 0;
    scroll_en = 1'b1; scroll_dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame_event(t);
      total += t;
    end
    vectors++;
    if (total !== 3) begin
      miscompares++;
      $display("FAIL tick_count: got %0d pulses expected 3", total);
    end
    h_cnt = 10'd636; v_cnt = 10'd0;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd2 || pixel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL scroll_wrap: addr=%0d valid=%0b expected 2/1", pixel_addr, pixel_valid);
    end
    scroll_dir = 1'b1;
    for (int i = 0; i < 4; i++) frame_event(t);
    scroll_en = 1'b0;
    frame_event(t);
    h_cnt = 10'd0; v_cnt = 10'd0;
    tick();
    tick();
    vectors++;
    if (pixel_addr !== 17'd159 || pixel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL scroll_dec_hold: addr=%0d valid=%0b expected 159/1", pixel_addr, pixel_valid);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    scroll_en = 1'b1; scroll_dir = 1'b0;
    frame_event(t);
    frame_event(t);
    h_cnt = 10'd40; v_cnt = 10'd100;
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (pixel_addr !== 17'd0 || pixel_valid !== 1'b0 || frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: addr=%0d valid=%0b tick=%0b expected 0/0/0", pixel_addr, pixel_valid, frame_tick);
    end
    rst = 1'b1;
    h_cnt = 10'd636; v_cnt = 10'd0;
    tick();
    vectors++;
    if (pixel_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release1: valid=%0b expected 0", pixel_valid);
    end
    tick();
    vectors++;
    if (pixel_addr !== 17'd159 || pixel_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release2: addr=%0d valid=%0b expected 159/1", pixel_addr, pixel_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_sel();
    test_mirror();
    test_invisible_clamp();
    test_scroll();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
